fb_pixel_sink: RTL and testbench
================================

# fb_pixel_sink

Receiving end of the pixel-write interface driven by the game control FSM (`X`, `Y`, `colour`, `writeEn`). It clips each write to the 160×120 playfield and converts it to a linear framebuffer address. It then issues one write per clock to the framebuffer RAM. It also owns full-screen clear: while a clear sweep runs, incoming pixels are held in a small FIFO, because the producer has no backpressure.

## Interface
- `FIFO_DEPTH`, 8: pixel FIFO entries (power of two, ≥2).
- `BG_COLOUR`, 6'b000000: colour written by a clear sweep.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `x` in 8: pixel column from producer.
- `y` in 7: pixel row from producer.
- `colour` in 6: pixel colour.
- `write_en` in 1: pixel valid; sampled every cycle, no ready signal.
- `clear_req` in 1: start a clear sweep; one-cycle pulse.
- `fb_addr` out 15: framebuffer address, y*160+x.
- `fb_data` out 6: framebuffer write data.
- `fb_wren` out 1: framebuffer write strobe.
- `busy` out 1: high while a sweep is running.
- `clear_done` out 1: one-cycle pulse after the last sweep write.
- `overflow` out 1: sticky; a pixel was dropped because the FIFO was full.

## Operation
- Reset: all outputs 0, FIFO empty, state IDLE.
  - A reset during a sweep aborts it.
  - No `clear_done` is issued for an aborted sweep.
- Stage 1 register: captures `x`, `y`, `colour` when `write_en` is high.
  - Clip rule: accepted only if x<160 and y<120; clipped writes vanish.
  - Address = (y<<7)+(y<<5)+x, 15-bit unsigned, max 19199.
- Order is preserved:
  - IDLE and FIFO empty: stage 1 goes straight to the output register.
  - Otherwise: stage 1 is pushed to the FIFO, and the FIFO head is popped to the output one per cycle.
- IDLE with FIFO non-empty: pop one entry per cycle, while stage 1 pushes in the same cycle. A simultaneous push and pop is legal at any occupancy, including full.
- CLEARING: output register is the sweep (`fb_addr` 0..19199, `fb_data`=BG_COLOUR, `fb_wren`=1), and no FIFO pop occurs.
  - Valid stage-1 pixels are pushed.
  - Push onto a full FIFO drops the pixel and sets `overflow`. `overflow` is cleared only by reset.
- States and transitions:
  - IDLE → CLEARING on `clear_req`. A stage-1 pixel pending in that cycle goes to the FIFO, so it lands after the sweep.
  - CLEARING → IDLE after address 19199 is written; `clear_done` pulses in the cycle following the last write.
  - `clear_req` during CLEARING is ignored (no restart).

## Timing
- Pass-through latency (IDLE, FIFO empty): `write_en` in cycle N → `fb_wren` with matching addr/data in cycle N+2.
- Throughput: one framebuffer write per cycle.
- Sweep length: exactly 19200 consecutive `fb_wren` cycles.
  - First sweep write is in the cycle after `clear_req` is sampled.
  - `busy` is high for exactly those cycles.
- Post-sweep drain: the FIFO head appears on `fb_wren` in the first IDLE cycle, then one entry per cycle.
- Outputs are registered; `fb_wren`=0 whenever no write is issued. `fb_addr`/`fb_data` hold their last values in that case.

## Configuration
- `FB_CLIP_COUNT_EN` defined:
  - Adds output `clip_count` [15:0], reset 0.
  - Increments on every `write_en` cycle that fails the clip rule.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; clipped writes are silently discarded.

## Structure
- `fb_pkg` holds:
  - `FB_W`=160, `FB_H`=120, `FB_SIZE`=19200.
  - `FB_ADDR_W`=15, `COLOUR_W`=6.
  - Sweep-state enum {IDLE, CLEARING}.
  - Packed pixel struct {addr, colour}.
- Sub-module `pixel_fifo`: synchronous FIFO of the pixel struct.
  - Ports: `push`, `pop`, `full`, `empty`, `head`.
  - Full/empty via pointers with a wrap bit.

## Test plan
- Pass-through: after reset, write (x=10, y=5, c=6'h2A) in cycle N → `fb_wren`=1, `fb_addr`=810, `fb_data`=6'h2A in cycle N+2.
- Clipping: writes at (160,0), (0,120), (255,127) → no `fb_wren`; with `FB_CLIP_COUNT_EN`, `clip_count`=3. Then (159,119) → `fb_addr`=19199.
- Clear: `clear_req` pulse →
  - 19200 writes of BG_COLOUR at addresses 0..19199 in order;
  - `busy` high exactly those cycles;
  - `clear_done` one pulse, one cycle after the last write.
- Buffered during clear: 5 pixels sent mid-sweep → none emitted during the sweep; all 5 emitted in order immediately after, one per cycle; `overflow`=0.
- Overflow: 10 pixels mid-sweep with FIFO_DEPTH=8 → first 8 emitted after the sweep, last 2 lost; `overflow`=1 until reset.
- Reset mid-sweep: `reset_n`=0 at sweep address 5000 →
  - next cycle `fb_wren`=0, `busy`=0, FIFO empty;
  - no `clear_done`;
  - a subsequent pixel write follows 2-cycle pass-through.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer pixel sink.
// Optional build macro used by the top: FB_CLIP_COUNT_EN.
package fb_pkg;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_SIZE   = 19200;
    localparam int FB_ADDR_W = 15;
    localparam int COLOUR_W  = 6;

    typedef enum logic {
        IDLE,
        CLEARING
    } sweep_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [COLOUR_W-1:0]  colour;
    } pixel_t;

    // Linear address y*160+x built from shifts: 160 = 128 + 32.
    function automatic logic [FB_ADDR_W-1:0] fb_addr_of(input logic [7:0] px, input logic [6:0] py);
        logic [FB_ADDR_W-1:0] yw;
        yw = {8'd0, py};
        return (yw << 7) + (yw << 5) + {7'd0, px};
    endfunction

endpackage

// File: rtl/fb_pixel_sink_pixel_fifo.sv
// Small synchronous FIFO of pixel_t entries.
// Full/empty come from read/write pointers carrying an extra wrap bit.
// A push is honoured while full when a pop happens in the same cycle.
module pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  pixel_t din,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output pixel_t head
);

    localparam int AW = $clog2(DEPTH);

    pixel_t         mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    // Storage array; contents need no reset because the pointers gate validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointer update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_pixel_sink.sv
// Framebuffer pixel sink: clips producer writes to 160x120, converts to a
// linear address, and issues one framebuffer write per clock. Owns the
// full-screen clear sweep; pixels arriving during a sweep are parked in a FIFO.
// Optional macro FB_CLIP_COUNT_EN adds a saturating clipped-write counter.
module fb_pixel_sink
    import fb_pkg::*;
#(
    parameter int                  FIFO_DEPTH = 8,
    parameter logic [COLOUR_W-1:0] BG_COLOUR  = 6'b000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [5:0]  colour,
    input  logic        write_en,
    input  logic        clear_req,
    output logic [14:0] fb_addr,
    output logic [5:0]  fb_data,
    output logic        fb_wren,
    output logic        busy,
    output logic        clear_done,
    output logic        overflow
`ifdef FB_CLIP_COUNT_EN
    ,
    output logic [15:0] clip_count
`endif
);

    sweep_state_t          state_reg;
    logic [FB_ADDR_W-1:0]  sweep_cnt_reg;
    logic                  s1_valid_reg;
    pixel_t                s1_pix_reg;

    logic                  in_bounds;
    logic                  sweep_last;
    logic                  idle_path;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pixel_drop;
    pixel_t                fifo_head;
    logic                  idle_out_valid;
    pixel_t                idle_out_pix;

    assign in_bounds = (x < 8'(FB_W)) && (y < 7'(FB_H));

    // Stage 1: capture in-bounds pixels and precompute their address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_pix_reg   <= '0;
        end else begin
            s1_valid_reg <= write_en && in_bounds;
            if (write_en && in_bounds) begin
                s1_pix_reg.addr   <= fb_addr_of(x, y);
                s1_pix_reg.colour <= colour;
            end
        end
    end

    // The cycle that retires the last sweep write behaves like IDLE so the
    // FIFO head lands on the output in the very first idle cycle.
    assign sweep_last = (state_reg == CLEARING) && (sweep_cnt_reg == 15'(FB_SIZE));
    assign idle_path  = ((state_reg == IDLE) && !clear_req) || sweep_last;
    assign fifo_pop   = idle_path && !fifo_empty;
    assign fifo_push  = s1_valid_reg && !(idle_path && fifo_empty);
    assign pixel_drop = fifo_push && fifo_full && !fifo_pop;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     (s1_pix_reg),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Idle output source: FIFO head first (keeps order), else direct stage 1.
    always_comb begin
        idle_out_valid = 1'b0;
        idle_out_pix   = s1_pix_reg;
        if (!fifo_empty) begin
            idle_out_valid = 1'b1;
            idle_out_pix   = fifo_head;
        end else if (s1_valid_reg) begin
            idle_out_valid = 1'b1;
        end
    end

    // Sweep FSM with registered framebuffer outputs and status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            sweep_cnt_reg <= '0;
            fb_addr       <= '0;
            fb_data       <= '0;
            fb_wren       <= 1'b0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            fb_wren    <= 1'b0;
            clear_done <= 1'b0;
            if (pixel_drop) begin
                overflow <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (clear_req) begin
                        state_reg     <= CLEARING;
                        busy          <= 1'b1;
                        fb_addr       <= '0;
                        fb_data       <= BG_COLOUR;
                        fb_wren       <= 1'b1;
                        sweep_cnt_reg <= 15'd1;
                    end else if (idle_out_valid) begin
                        fb_addr <= idle_out_pix.addr;
                        fb_data <= idle_out_pix.colour;
                        fb_wren <= 1'b1;
                    end
                end
                CLEARING: begin
                    if (sweep_last) begin
                        state_reg  <= IDLE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                        if (idle_out_valid) begin
                            fb_addr <= idle_out_pix.addr;
                            fb_data <= idle_out_pix.colour;
                            fb_wren <= 1'b1;
                        end
                    end else begin
                        fb_addr       <= sweep_cnt_reg;
                        fb_data       <= BG_COLOUR;
                        fb_wren       <= 1'b1;
                        sweep_cnt_reg <= sweep_cnt_reg + 15'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FB_CLIP_COUNT_EN
    logic [15:0] clip_count_reg;

    // Count producer writes rejected by the playfield bounds, saturating.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clip_count_reg <= '0;
        end else if (write_en && !in_bounds && (clip_count_reg != 16'hFFFF)) begin
            clip_count_reg <= clip_count_reg + 16'd1;
        end
    end

    assign clip_count = clip_count_reg;
`endif

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Scoreboard bench for fb_pixel_sink: stimulus pushes expected writes,
// a negedge monitor pops and compares every framebuffer write.
module tb_fb_pixel_sink;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [5:0]  colour;
    logic        write_en;
    logic        clear_req;
    logic [14:0] fb_addr;
    logic [5:0]  fb_data;
    logic        fb_wren;
    logic        busy;
    logic        clear_done;
    logic        overflow;
`ifdef FB_CLIP_COUNT_EN
    logic [15:0] clip_count;
`endif

    typedef struct {
        logic [14:0] addr;
        logic [5:0]  data;
        logic        sweep;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fb_pixel_sink #(
        .FIFO_DEPTH (8),
        .BG_COLOUR  (6'b000000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .write_en   (write_en),
        .clear_req  (clear_req),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_wren    (fb_wren),
        .busy       (busy),
        .clear_done (clear_done),
        .overflow   (overflow)
`ifdef FB_CLIP_COUNT_EN
        ,
        .clip_count (clip_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_px(input logic [14:0] a, input logic [5:0] d);
        exp_t e;
        e.addr = a; e.data = d; e.sweep = 1'b0;
        sb.push_back(e);
    endtask

    // Drive one pixel for one cycle; consecutive calls give back-to-back writes.
    task automatic drive(input logic [7:0] px, input logic [6:0] py, input logic [5:0] pc);
        x = px; y = py; colour = pc; write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
        $display("drive x=%0d y=%0d colour=%0h", px, py, pc);
    endtask

    // Queue the expected sweep writes 0..last, then pulse clear_req.
    task automatic start_clear(input int last);
        exp_t e;
        for (int i = 0; i <= last; i++) begin
            e.addr = 15'(i); e.data = 6'b000000; e.sweep = 1'b1;
            sb.push_back(e);
        end
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        $display("clear_req issued");
    endtask

    task automatic wait_clear_done(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (clear_done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("clear_done_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: every write is matched against the scoreboard head.
    initial begin
        exp_t e;
        bit   prev_last;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (fb_wren) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0h required no write", fb_addr, fb_data);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(fb_addr), 32'(e.addr));
                    check("wr_data", 32'(fb_data), 32'(e.data));
                    check("wr_busy", 32'(busy), 32'(e.sweep));
                    if (!e.sweep) $display("write addr=%0d data=%0h", fb_addr, fb_data);
                end
            end else if (busy) begin
                check("busy_without_write", 32'(busy), 32'd0);
            end
            if (clear_done || prev_last) check("clear_done_timing", 32'(clear_done), 32'(prev_last));
            prev_last = fb_wren && busy && (fb_addr == 15'd19199);
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset_n = 1'b0; x = '0; y = '0; colour = '0; write_en = 1'b0; clear_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wren", 32'(fb_wren), 32'd0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_data", 32'(fb_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clear_done", 32'(clear_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Pass-through latency: write in cycle N appears in cycle N+2.
        expect_px(15'd810, 6'h2A);
        drive(8'd10, 7'd5, 6'h2A);
        check("pt_wren_n1", 32'(fb_wren), 32'd0);
        @(negedge clk);
        check("pt_wren_n2", 32'(fb_wren), 32'd1);
        check("pt_addr_n2", 32'(fb_addr), 32'd810);
        repeat (2) @(negedge clk);

        // Back-to-back writes.
        expect_px(15'd3, 6'h01);
        expect_px(15'd160, 6'h3F);
        expect_px(15'd8100, 6'h15);
        drive(8'd3, 7'd0, 6'h01);
        drive(8'd0, 7'd1, 6'h3F);
        drive(8'd100, 7'd50, 6'h15);
        repeat (3) @(negedge clk);

        // Clipping boundaries, then the last legal pixel.
        drive(8'd160, 7'd0, 6'h11);
        drive(8'd0, 7'd120, 6'h12);
        drive(8'd255, 7'd127, 6'h13);
        expect_px(15'd19199, 6'h07);
        drive(8'd159, 7'd119, 6'h07);
        repeat (3) @(negedge clk);
`ifdef FB_CLIP_COUNT_EN
        check("clip_count", 32'(clip_count), 32'd3);
`endif

        // Clear with five pixels buffered mid-sweep.
        start_clear(19199);
        repeat (100) @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            expect_px(15'(i * 161), 6'(i));
            drive(8'(i), 7'(i), 6'(i));
        end
        wait_clear_done(found);
        if (found) begin
            for (int i = 0; i < 5; i++) begin
                check("drain5_wren", 32'(fb_wren), 32'd1);
                @(negedge clk);
            end
            check("drain5_end", 32'(fb_wren), 32'd0);
        end
        check("no_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);

        // Overflow: ten pixels mid-sweep, only eight fit.
        start_clear(19199);
        repeat (100) @(negedge clk);
        for (int i = 10; i < 20; i++) begin
            if (i < 18) expect_px(15'(i), 6'(i));
            drive(8'(i), 7'd0, 6'(i));
        end
        wait_clear_done(found);
        if (found) begin
            for (int i = 0; i < 8; i++) begin
                check("drain8_wren", 32'(fb_wren), 32'd1);
                @(negedge clk);
            end
            check("drain8_end", 32'(fb_wren), 32'd0);
        end
        check("overflow_set", 32'(overflow), 32'd1);
        expect_px(15'd7, 6'h22);
        drive(8'd7, 7'd0, 6'h22);
        repeat (3) @(negedge clk);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Reset mid-sweep at address 5000; buffered pixels must vanish.
        start_clear(5000);
        repeat (100) @(negedge clk);
        drive(8'd1, 7'd2, 6'h31);
        drive(8'd2, 7'd3, 6'h32);
        found = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (fb_wren && fb_addr == 15'd5000) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("addr5000_timeout", 32'd0, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_wren", 32'(fb_wren), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_clear_done", 32'(clear_done), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        expect_px(15'd1127, 6'h11);
        drive(8'd7, 7'd7, 6'h11);
        check("post_rst_n1", 32'(fb_wren), 32'd0);
        @(negedge clk);
        check("post_rst_n2", 32'(fb_wren), 32'd1);
        check("post_rst_addr", 32'(fb_addr), 32'd1127);
        repeat (20) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
